// File: rtl/buffer_mult_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// buffer_mult_ctrl_pkg
// Shared widths and FSM state encodings for the buffer/multiplier controller.
//   CNN_XLEN  : operand/product width
//   ADDR_B    : weight buffer address width
//   CAP_B     : log2 of the maximum vector length
//   AUG_FCT_B : multiplier augmentation factor width
//   state_e   : controller FSM states
// ---------------------------------------------------------------------------
package buffer_mult_ctrl_pkg;

    localparam int CNN_XLEN  = 16;
    localparam int ADDR_B    = 4;
    localparam int CAP_B     = 4;
    localparam int AUG_FCT_B = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/buffer_mult_ctrl_vld_pipe.sv
// ---------------------------------------------------------------------------
// vld_pipe
// Shift register tracking which cycles carry a real product through the
// buffer read + multiplier datapath.
//   clk, reset  : clock, asynchronous active-high reset (clears all stages)
//   vld_i       : an operand pair was issued this cycle
//   vld_o       : the product currently on the multiplier output is real
//   last_only_o : no stage other than the final one is occupied, so the
//                 pipe will be empty after this cycle
// ---------------------------------------------------------------------------
module vld_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic vld_i,
    output logic vld_o,
    output logic last_only_o
);

    logic [DEPTH-1:0] stage_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= vld_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign vld_o       = stage_q[DEPTH-1];
    assign last_only_o = ((stage_q & ~(DEPTH'(1) << (DEPTH - 1))) == '0);

endmodule

// File: rtl/buffer_mult_ctrl.sv
// ---------------------------------------------------------------------------
// buffer_mult_ctrl
// Controller for a dot product between a stored weight vector and a stream
// of activations. Host writes reach the weight buffer only while idle. A job
// walks len weights from base_addr, pairing each with one activation, and
// accumulates the signed products that come back MULT_LAT cycles after the
// buffer read.
//   clk, reset        : clock, asynchronous active-high reset
//   start/base_addr/len : job request (len 0 finishes immediately)
//   busy/done/result  : job status, one-cycle done pulse, held dot product
//   wr_req/addr/data  : host weight write, wr_ready while idle
//   a_valid/a_data    : activation stream, a_ready while running
//   wrb/_addr/_data   : buffer write port
//   rdb_addr          : buffer read address
//   A                 : operand to the multiplier input register
//   prod              : signed multiplier result
// ---------------------------------------------------------------------------
module buffer_mult_ctrl #(
    parameter int DATA_WID  = buffer_mult_ctrl_pkg::CNN_XLEN,
    parameter int ADDR_B    = buffer_mult_ctrl_pkg::ADDR_B,
    parameter int CAP_B     = buffer_mult_ctrl_pkg::CAP_B,
    parameter int AUG_FCT_B = buffer_mult_ctrl_pkg::AUG_FCT_B,
    parameter int MULT_LAT  = 1,
    parameter int ACC_WID   = DATA_WID + CAP_B
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_B-1:0]   base_addr,
    input  logic [CAP_B:0]      len,
    output logic                busy,
    output logic                done,
    output logic [ACC_WID-1:0]  result,
    input  logic                wr_req,
    input  logic [ADDR_B-1:0]   wr_addr,
    input  logic [DATA_WID-1:0] wr_data,
    output logic                wr_ready,
    input  logic                a_valid,
    input  logic [DATA_WID-1:0] a_data,
    output logic                a_ready,
    output logic                wrb,
    output logic [ADDR_B-1:0]   wrb_addr,
    output logic [DATA_WID-1:0] wrb_data,
    output logic [ADDR_B-1:0]   rdb_addr,
    output logic [DATA_WID-1:0] A,
    input  logic [DATA_WID-1:0] prod
);

    import buffer_mult_ctrl_pkg::*;

    // One stage for the registered buffer read, MULT_LAT for the multiplier.
    localparam int PIPE_DEPTH = 1 + MULT_LAT;

    state_e                       state_q, state_d;
    logic        [ADDR_B-1:0]     base_q;
    logic        [ADDR_B-1:0]     rdb_addr_q;
    logic        [CAP_B:0]        len_q;
    logic        [CAP_B:0]        idx_q;
    logic        [CAP_B:0]        idx_inc;
    logic        [DATA_WID-1:0]   a_q;
    logic signed [ACC_WID-1:0]    acc_q, acc_d;
    logic        [ACC_WID-1:0]    result_q;
    logic                         job_start;
    logic                         issue;
    logic                         last_issue;
    logic                         pipe_vld;
    logic                         pipe_last;
    logic                         unused_aug;

    // The augmentation factor belongs to the external multiplier.
    assign unused_aug = ^AUG_FCT_B;

    assign job_start  = (state_q == ST_IDLE) && start;
    assign issue      = (state_q == ST_RUN) && a_valid;
    assign idx_inc    = idx_q + 1'b1;
    assign last_issue = issue && (idx_inc == len_q);

    vld_pipe #(
        .DEPTH(PIPE_DEPTH)
    ) u_vld_pipe (
        .clk        (clk),
        .reset      (reset),
        .vld_i      (issue),
        .vld_o      (pipe_vld),
        .last_only_o(pipe_last)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = (len == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (last_issue) state_d = ST_DRAIN;
            // Leave once the only product still in flight is being summed now.
            ST_DRAIN: if (pipe_last) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        a_ready  = 1'b0;
        wr_ready = 1'b0;
        wrb      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wr_ready = 1'b1;
                // Keep the buffer write strobe quiet while reset is held.
                wrb      = wr_req & ~reset;
            end
            ST_RUN: begin
                busy    = 1'b1;
                a_ready = 1'b1;
            end
            ST_DRAIN: busy = 1'b1;
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign wrb_addr = wr_addr;
    assign wrb_data = wr_data;

    // Read address and operand are presented in the issue cycle so the
    // buffer and operand register capture them together; they hold otherwise.
    assign rdb_addr = issue ? (base_q + ADDR_B'(idx_q)) : rdb_addr_q;
    assign A        = issue ? a_data : a_q;
    assign result   = result_q;

    always_comb begin
        acc_d = acc_q;
        if (job_start) begin
            acc_d = '0;
        end else if (pipe_vld) begin
            acc_d = acc_q + ACC_WID'(signed'(prod));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            rdb_addr_q <= '0;
            a_q        <= '0;
            acc_q      <= '0;
            result_q   <= '0;
        end else begin
            acc_q      <= acc_d;
            rdb_addr_q <= rdb_addr;
            a_q        <= A;
            if (job_start) begin
                base_q <= base_addr;
                len_q  <= len;
                idx_q  <= '0;
            end else if (issue) begin
                idx_q  <= idx_inc;
            end
            // Capture the sum including any product being added this cycle.
            if (state_d == ST_DONE) begin
                result_q <= acc_d;
            end
        end
    end

endmodule

// File: tb/tb_buffer_mult_ctrl.sv
// ---------------------------------------------------------------------------
// tb_buffer_mult_ctrl
// Drives buffer_mult_ctrl attached to a registered-read weight buffer and a
// one-cycle multiplier (operand register + product register). Jobs come from
// a table of directed vectors; reset behaviour is exercised by hand-written
// sequences. Latency is counted in clock edges after the edge that samples
// start, up to the edge that raises done.
// ---------------------------------------------------------------------------
module tb_buffer_mult_ctrl;

    import buffer_mult_ctrl_pkg::*;

    localparam int DW = CNN_XLEN;
    localparam int AB = ADDR_B;
    localparam int CB = CAP_B;
    localparam int AW = DW + CB;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AB-1:0] base_addr;
    logic [CB:0]   len;
    logic          busy;
    logic          done;
    logic [AW-1:0] result;
    logic          wr_req;
    logic [AB-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          a_valid;
    logic [DW-1:0] a_data;
    logic          a_ready;
    logic          wrb;
    logic [AB-1:0] wrb_addr;
    logic [DW-1:0] wrb_data;
    logic [AB-1:0] rdb_addr;
    logic [DW-1:0] A;
    logic [DW-1:0] prod;

    buffer_mult_ctrl #(
        .DATA_WID (DW),
        .ADDR_B   (AB),
        .CAP_B    (CB),
        .AUG_FCT_B(AUG_FCT_B),
        .MULT_LAT (1),
        .ACC_WID  (AW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .base_addr(base_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .a_valid  (a_valid),
        .a_data   (a_data),
        .a_ready  (a_ready),
        .wrb      (wrb),
        .wrb_addr (wrb_addr),
        .wrb_data (wrb_data),
        .rdb_addr (rdb_addr),
        .A        (A),
        .prod     (prod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Weight buffer with registered read, operand register, product register.
    logic signed [DW-1:0] mem [0:(1<<AB)-1];
    logic signed [DW-1:0] rd_q;
    logic signed [DW-1:0] a_reg;
    logic signed [DW-1:0] prod_q;

    always @(posedge clk) begin
        if (wrb) mem[wrb_addr] <= wrb_data;
        rd_q   <= mem[rdb_addr];
        a_reg  <= A;
        prod_q <= DW'(rd_q * a_reg);
    end
    assign prod = prod_q;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [AB-1:0]        base;
        logic [CB:0]          len;
        logic signed [DW-1:0] aval;
        bit                   alt;        // a_valid low on odd cycles
        bit                   wr_during;  // host keeps writing while busy
        logic [AW-1:0]        exp_res;
        int                   exp_lat;
    } vec_t;

    function automatic vec_t mk(input int b, input int l, input int a, input bit alt,
                                input bit wr, input int res, input int lat);
        vec_t v;
        v.base      = AB'(b);
        v.len       = (CB+1)'(l);
        v.aval      = DW'(a);
        v.alt       = alt;
        v.wr_during = wr;
        v.exp_res   = AW'(res);
        v.exp_lat   = lat;
        return v;
    endfunction

    task automatic wr_word(input int addr, input int data);
        @(negedge clk);
        wr_req  = 1'b1;
        wr_addr = AB'(addr);
        wr_data = DW'(data);
        #1;
        chk("wr_ready_idle", wr_ready, 1);
        chk("wrb_pass", wrb, 1);
    endtask

    task automatic run_job(input vec_t v);
        int            cyc;
        int            issues;
        bit            got_done;
        bit            seen_ready;
        logic [AB-1:0] last_addr;
        cyc        = 0;
        issues     = 0;
        got_done   = 0;
        seen_ready = 0;
        last_addr  = '0;
        @(negedge clk);
        start     = 1'b1;
        base_addr = v.base;
        len       = v.len;
        a_valid   = 1'b0;
        @(posedge clk);
        while (!got_done && cyc < 64) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                got_done = 1;
                wr_req   = 1'b0;
                a_valid  = 1'b0;
            end else begin
                wr_req  = v.wr_during;
                wr_addr = '0;
                wr_data = DW'(99);
                a_valid = !(v.alt && (cyc % 2 == 1));
                a_data  = v.aval;
                #1;
                if (a_ready) seen_ready = 1;
                if (v.wr_during) begin
                    chk("wr_ready_busy", wr_ready, 0);
                    chk("wrb_busy", wrb, 0);
                end
                if (a_ready && a_valid) begin
                    last_addr = AB'(v.base + issues);
                    chk("rdb_addr_issue", rdb_addr, last_addr);
                    issues++;
                end else if (a_ready) begin
                    chk("rdb_addr_bubble", rdb_addr, last_addr);
                end
                cyc++;
            end
        end
        if (!got_done) begin
            chk("done_timeout", 0, 1);
            a_valid = 1'b0;
            wr_req  = 1'b0;
        end else begin
            chk("latency", cyc, v.exp_lat);
            chk("result", result, v.exp_res);
            chk("busy_in_done", busy, 1);
            chk("issue_count", issues, v.len);
            if (v.len == 0) chk("a_ready_len0", seen_ready, 0);
            @(negedge clk);
            chk("done_pulse", done, 0);
            chk("busy_idle", busy, 0);
            chk("result_hold", result, v.exp_res);
        end
        $display("job base=%0d len=%0d a=%0d alt=%0d wr=%0d -> result=%0h lat=%0d",
                 v.base, v.len, v.aval, v.alt, v.wr_during, result, cyc);
    endtask

    vec_t vecs [7];

    initial begin
        vecs[0] = mk(0,  4,  1, 0, 0,  10, 6);
        vecs[1] = mk(0,  4,  1, 1, 0,  10, 9);
        vecs[2] = mk(0,  4,  3, 0, 1,  30, 6);
        vecs[3] = mk(14, 4,  2, 0, 0,  16, 6);
        vecs[4] = mk(0,  0,  5, 0, 0,   0, 0);
        vecs[5] = mk(2,  1, -4, 0, 0, -12, 3);
        vecs[6] = mk(0,  4, -1, 1, 1, -10, 9);

        // Reset state, with a host write request that must not reach the buffer.
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        len       = '0;
        wr_req    = 1'b1;
        wr_addr   = AB'(5);
        wr_data   = DW'(123);
        a_valid   = 1'b0;
        a_data    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_wrb", wrb, 0);
        chk("rst_rdb_addr", rdb_addr, 0);
        chk("rst_A", A, 0);
        reset  = 1'b0;
        wr_req = 1'b0;

        wr_word(0, 1);
        wr_word(1, 2);
        wr_word(2, 3);
        wr_word(3, 4);
        wr_word(14, 7);
        wr_word(15, -2);
        wr_word(8, -3);
        wr_word(9, 5);
        @(negedge clk);
        wr_req = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_job(vecs[i]);
        end

        // Reset in the middle of a job, with products still in flight.
        @(negedge clk);
        start     = 1'b1;
        base_addr = '0;
        len       = (CB+1)'(4);
        a_valid   = 1'b1;
        a_data    = DW'(1);
        @(posedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_a_ready", a_ready, 0);
        chk("midrst_result", result, 0);
        chk("midrst_rdb_addr", rdb_addr, 0);
        chk("midrst_A", A, 0);
        chk("midrst_wrb", wrb, 0);
        $display("mid-job reset: busy=%0d a_ready=%0d result=%0h", busy, a_ready, result);
        @(negedge clk);
        a_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        run_job(mk(8, 2, 2, 0, 0, 4, 4));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
